logic_gate_pipe: RTL and testbench



---
 rtl/logic_gate_pipe.sv | 110 +++++++++++
 tb/tb_logic_gate_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_pipe.sv
// ============================================================================
// logic_gate_pipe : pipelined WIDTH-bit bitwise logic unit with valid/ready
// Optional macro LOGIC_GATE_PIPE_PARITY_EN adds the y_par output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module logic_gate_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             busy
`ifdef LOGIC_GATE_PIPE_PARITY_EN
    ,
    output logic             y_par
`endif
);

    localparam logic [2:0] c_op_not  = 3'd0;
    localparam logic [2:0] c_op_buf  = 3'd1;
    localparam logic [2:0] c_op_and  = 3'd2;
    localparam logic [2:0] c_op_or   = 3'd3;
    localparam logic [2:0] c_op_xor  = 3'd4;
    localparam logic [2:0] c_op_nand = 3'd5;
    localparam logic [2:0] c_op_nor  = 3'd6;
    localparam logic [2:0] c_op_xnor = 3'd7;

    logic [STAGES-1:0] r_v;
    logic [WIDTH-1:0]  r_d [STAGES];
    logic [STAGES-1:0] w_rdy;
    logic [WIDTH-1:0]  w_res;

    always_comb begin
        w_res = '0;
        case (op)
            c_op_not:  w_res = ~a;
            c_op_buf:  w_res = a;
            c_op_and:  w_res = a & b;
            c_op_or:   w_res = a | b;
            c_op_xor:  w_res = a ^ b;
            c_op_nand: w_res = ~(a & b);
            c_op_nor:  w_res = ~(a | b);
            c_op_xnor: w_res = ~(a ^ b);
            default:   w_res = '0;
        endcase
    end

    // Stage k can advance if any stage from k to the output is empty or the
    // consumer takes the head; flattened form of the ripple ready chain.
    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_rdy
            assign w_rdy[k] = ~(&r_v[STAGES-1:k]) | out_ready;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= 1'b0;
                r_d[k] <= '0;
            end
        end else begin
            if (w_rdy[0]) begin
                r_v[0] <= in_valid;
                if (in_valid) r_d[0] <= w_res;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_rdy[k]) begin
                    r_v[k] <= r_v[k-1];
                    if (r_v[k-1]) r_d[k] <= r_d[k-1];
                end
            end
        end
    end

`ifdef LOGIC_GATE_PIPE_PARITY_EN
    logic [STAGES-1:0] r_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p <= '0;
        end else begin
            if (w_rdy[0] && in_valid) r_p[0] <= ^w_res;
            for (int k = 1; k < STAGES; k++) begin
                if (w_rdy[k] && r_v[k-1]) r_p[k] <= r_p[k-1];
            end
        end
    end

    assign y_par = r_p[STAGES-1];
`endif

    assign in_ready  = w_rdy[0];
    assign out_valid = r_v[STAGES-1];
    assign y         = r_d[STAGES-1];
    assign busy      = |r_v;

endmodule

`default_nettype wire

// File: tb/tb_logic_gate_pipe.sv
// ============================================================================
// tb_logic_gate_pipe : directed and randomized bench for logic_gate_pipe
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_logic_gate_pipe;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         busy;
`ifdef LOGIC_GATE_PIPE_PARITY_EN
    logic         y_par;
`endif

    int total = 0;
    int bad   = 0;
    logic [W-1:0] q[$];

    logic_gate_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
`ifdef LOGIC_GATE_PIPE_PARITY_EN
        ,
        .y_par     (y_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Truth table per op, indexed by {a_bit, b_bit}.
    function automatic logic [3:0] truth(input logic [2:0] o);
        case (o)
            3'd0: truth = 4'b0011;
            3'd1: truth = 4'b1100;
            3'd2: truth = 4'b1000;
            3'd3: truth = 4'b1110;
            3'd4: truth = 4'b0110;
            3'd5: truth = 4'b0111;
            3'd6: truth = 4'b0001;
            default: truth = 4'b1001;
        endcase
    endfunction

    function automatic logic [W-1:0] ref_y(input logic [2:0] o, input logic [W-1:0] av,
                                           input logic [W-1:0] bv);
        logic [3:0] t;
        t = truth(o);
        for (int i = 0; i < W; i++) ref_y[i] = t[{av[i], bv[i]}];
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [2:0] o, input logic rdy);
        in_valid  = v;
        a         = av;
        b         = bv;
        op        = o;
        out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle against the queue model: occupancy decides busy/in_ready,
    // the queue head decides y whenever a result is presented.
    task automatic sb_cycle(output bit acc_in, output bit acc_out);
        @(negedge clk);
        chk("sb_busy", busy, q.size() != 0);
        chk("sb_in_ready", in_ready, (q.size() < S) || out_ready);
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("sb_spurious", out_valid, 0);
            end else begin
                chk("sb_y", y, q[0]);
`ifdef LOGIC_GATE_PIPE_PARITY_EN
                chk("sb_par", y_par, ^q[0]);
`endif
            end
        end
        acc_out = out_valid && out_ready && (q.size() != 0);
        acc_in  = in_valid && in_ready;
        if (acc_out) void'(q.pop_front());
        if (acc_in) q.push_back(ref_y(op, a, b));
        tick();
    endtask

    logic [W-1:0] ops_exp [8];
    bit ai, ao;
    int nacc, nout, sent, got_n, cyc;
    bit flowing;

    initial begin
        ops_exp = '{8'h0F, 8'hF0, 8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3};
        rst_n = 1'b0;
        drive(0, 8'h00, 8'h00, 3'd0, 1);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();

        // Single NOT
        drive(1, 8'hA5, 8'h00, 3'd0, 1);
        @(negedge clk); chk("not_in_ready", in_ready, 1);
        tick();
        drive(0, 8'h00, 8'h00, 3'd0, 1);
        @(negedge clk); chk("not_busy1", busy, 1); chk("not_ov1", out_valid, 0);
        tick();
        @(negedge clk); chk("not_ov2", out_valid, 1); chk("not_y", y, 8'h5A); chk("not_busy2", busy, 1);
        tick();
        @(negedge clk); chk("not_ov3", out_valid, 0); chk("not_busy3", busy, 0);
        tick();

        // All ops back-to-back
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(1, 8'hF0, 8'hCC, i[2:0], 1);
            else drive(0, 8'h00, 8'h00, 3'd0, 1);
            @(negedge clk);
            if (i < 8) chk("ops_in_ready", in_ready, 1);
            if (i >= 2) begin
                chk("ops_ov", out_valid, 1);
                chk($sformatf("ops_y%0d", i - 2), y, ops_exp[i-2]);
            end
            tick();
        end
        tick();

        // Backpressure: 5 items, stalled output
        nacc = 0;
        for (int c = 0; c < 5; c++) begin
            drive(1, 8'h11 * (nacc + 1), 8'h5A, nacc[2:0], 0);
            sb_cycle(ai, ao);
            if (ai) nacc++;
        end
        @(negedge clk);
        chk("bp_accepted", nacc, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_y_hold", y, ref_y(3'd0, 8'h11, 8'h5A));
        tick();
        nout = 0;
        flowing = 0;
        for (int c = 0; c < 40 && nout < 5; c++) begin
            if (nacc < 5) drive(1, 8'h11 * (nacc + 1), 8'h5A, nacc[2:0], 1);
            else drive(0, 8'h00, 8'h00, 3'd0, 1);
            sb_cycle(ai, ao);
            if (ai) nacc++;
            if (flowing) chk("bp_gap", ao, 1);
            if (ao) begin
                nout++;
                flowing = 1;
            end
        end
        chk("bp_nout", nout, 5);
        drive(0, 8'h00, 8'h00, 3'd0, 1);
        sb_cycle(ai, ao);

        // Reset mid-operation with a full, stalled pipe
        for (int c = 0; c < 3; c++) begin
            drive(1, 8'h3C + c[7:0], 8'h0F, 3'd4, 0);
            sb_cycle(ai, ao);
        end
        @(negedge clk); chk("mr_full_ov", out_valid, 1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mr_ov", out_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_y", y, 0);
        chk("mr_in_ready", in_ready, 1);
        #2 rst_n = 1'b1;
        q.delete();
        drive(0, 8'h00, 8'h00, 3'd0, 1);
        tick();
        for (int c = 0; c < 3; c++) sb_cycle(ai, ao);
        drive(1, 8'h96, 8'h3C, 3'd7, 1);
        tick();
        drive(0, 8'h00, 8'h00, 3'd0, 1);
        @(negedge clk); chk("mr_lat_ov1", out_valid, 0);
        tick();
        @(negedge clk); chk("mr_lat_ov2", out_valid, 1); chk("mr_lat_y", y, ref_y(3'd7, 8'h96, 8'h3C));
        tick();
        tick();

`ifdef LOGIC_GATE_PIPE_PARITY_EN
        drive(1, 8'h07, 8'h00, 3'd1, 1);
        tick();
        drive(1, 8'h03, 8'h00, 3'd1, 1);
        tick();
        drive(0, 8'h00, 8'h00, 3'd0, 1);
        @(negedge clk); chk("par_y07", y, 8'h07); chk("par_p1", y_par, 1);
        tick();
        @(negedge clk); chk("par_y03", y, 8'h03); chk("par_p0", y_par, 0);
        tick();
        tick();
`endif

        // Randomized traffic against the queue model
        sent = 0;
        got_n = 0;
        cyc = 0;
        while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
            drive((sent < 1000) && ($urandom_range(0, 9) < 7), W'($urandom), W'($urandom),
                  3'($urandom), $urandom_range(0, 9) < 6);
            sb_cycle(ai, ao);
            if (ai) sent++;
            if (ao) got_n++;
            cyc++;
        end
        chk("rnd_sent", sent, 1000);
        chk("rnd_received", got_n, 1000);
        chk("rnd_drained", q.size(), 0);
        @(negedge clk); chk("rnd_idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
